// File: rtl/row_rotation_scheduler_pkg.sv
// Shared definitions for the row-rotation scheduler: FSM encoding and default geometry/latencies.
package row_rotation_scheduler_pkg;

   localparam int unsigned DEF_NROW     = 4;
   localparam int unsigned DEF_NCOL     = 4;
   localparam int unsigned DEF_MEM_LAT  = 1;
   localparam int unsigned DEF_PIPE_LAT = 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_e;

   // Index width that never collapses to zero bits for a single-entry range.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/row_rotation_scheduler_delay_line.sv
// Valid-tagged shift register with async clear and sync flush; DEPTH=0 is a pass-through.
module row_rotation_scheduler_delay_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned W     = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         inner_valid
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign out_valid   = in_valid;
         assign out_data    = in_data;
         assign inner_valid = 1'b0;
      end else begin : g_regs
         logic [DEPTH-1:0] v;
         logic [W-1:0]     d [DEPTH];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               v <= '0;
               for (int i = 0; i < int'(DEPTH); i++) d[i] <= '0;
            end else if (flush) begin
               v <= '0;
               for (int i = 0; i < int'(DEPTH); i++) d[i] <= '0;
            end else begin
               v[0] <= in_valid;
               d[0] <= in_data;
               for (int i = 1; i < int'(DEPTH); i++) begin
                  v[i] <= v[i-1];
                  d[i] <= d[i-1];
               end
            end
         end

         assign out_valid = v[DEPTH-1];
         assign out_data  = d[DEPTH-1];

         // Any valid op still upstream of the output stage.
         if (DEPTH > 1) begin : g_inner
            assign inner_valid = |v[DEPTH-2:0];
         end else begin : g_noinner
            assign inner_valid = 1'b0;
         end
      end
   endgenerate

endmodule

// File: rtl/row_rotation_scheduler.sv
// Column-sweep sequencer for the shared row-rotation datapath: issues row reads, tracks them
// through the read and rotation pipelines, and drains between columns so reads never pass writes.
module row_rotation_scheduler
   import row_rotation_scheduler_pkg::*;
#(
   parameter  int unsigned NROW     = DEF_NROW,
   parameter  int unsigned NCOL     = DEF_NCOL,
   parameter  int unsigned MEM_LAT  = DEF_MEM_LAT,
   parameter  int unsigned PIPE_LAT = DEF_PIPE_LAT,
   localparam int unsigned AW       = idx_w(NROW),
   localparam int unsigned CW       = idx_w(NCOL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   output logic          rot_valid,
   output logic [CW-1:0] rot_col,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr
);

   localparam int unsigned PW          = AW + CW;
   localparam bit          PIPE_STAGED = (PIPE_LAT > 0);

   state_e        state, state_d;
   logic [AW-1:0] row, row_d;
   logic [CW-1:0] col, col_d;
   logic          rd_en_d, busy_d, done_d;
   logic [AW-1:0] rd_addr_d;

   logic [PW-1:0] rd_pl, rot_pl;
   logic          rot_v, wr_v;
   logic          mem_inner, pipe_inner;
   logic          upstream_busy, drain_done;

   // Column tag is zeroed on idle slots so the datapath sideband stays quiet.
   assign rd_pl = {rd_addr, (rd_en ? col : CW'(0))};

   row_rotation_scheduler_delay_line #(.DEPTH(MEM_LAT), .W(PW)) u_mem_dly (
      .clk         (clk),
      .rst         (rst),
      .flush       (abort),
      .in_valid    (rd_en),
      .in_data     (rd_pl),
      .out_valid   (rot_v),
      .out_data    (rot_pl),
      .inner_valid (mem_inner)
   );

   row_rotation_scheduler_delay_line #(.DEPTH(PIPE_LAT), .W(AW)) u_pipe_dly (
      .clk         (clk),
      .rst         (rst),
      .flush       (abort),
      .in_valid    (rot_v),
      .in_data     (rot_pl[PW-1:CW]),
      .out_valid   (wr_v),
      .out_data    (wr_addr),
      .inner_valid (pipe_inner)
   );

   assign rot_valid = rot_v;
   assign rot_col   = rot_pl[CW-1:0];
   assign wr_en     = wr_v;

   // Column is finished when its last row is being written and nothing is behind it.
   assign upstream_busy = rd_en | mem_inner | (PIPE_STAGED ? (rot_v | pipe_inner) : 1'b0);
   assign drain_done    = wr_v && (wr_addr == AW'(NROW - 1)) && !upstream_busy;

   always_comb begin
      state_d = state;
      row_d   = row;
      col_d   = col;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_d = S_ISSUE;
               row_d   = '0;
               col_d   = '0;
            end
         end
         S_ISSUE: begin
            if (row == AW'(NROW - 1)) state_d = S_DRAIN;
            else                      row_d   = row + AW'(1);
         end
         S_DRAIN: begin
            if (drain_done) begin
               if (col == CW'(NCOL - 1)) begin
                  state_d = S_FIN;
               end else begin
                  state_d = S_ISSUE;
                  col_d   = col + CW'(1);
                  row_d   = AW'(col) + AW'(1);
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;

      rd_en_d   = (state_d == S_ISSUE);
      rd_addr_d = rd_en_d ? row_d : '0;
      busy_d    = (state_d == S_ISSUE) || (state_d == S_DRAIN);
      done_d    = (state_d == S_FIN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         row     <= '0;
         col     <= '0;
         rd_en   <= 1'b0;
         rd_addr <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_d;
         row     <= row_d;
         col     <= col_d;
         rd_en   <= rd_en_d;
         rd_addr <= rd_addr_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

endmodule

// File: tb/tb_row_rotation_scheduler.sv
// Directed bench for row_rotation_scheduler: per-cycle trace tables for a default and a small
// configuration, plus start-hold, abort, async-reset sequences and a row-buffer RAW scoreboard.
module tb_row_rotation_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Default configuration (NROW=NCOL=4, MEM_LAT=1, PIPE_LAT=1)
   logic       start_a, abort_a, busy_a, done_a, rd_en_a, rot_valid_a, wr_en_a;
   logic [1:0] rd_addr_a, rot_col_a, wr_addr_a;

   // Small configuration (NROW=NCOL=2, MEM_LAT=2, PIPE_LAT=0)
   logic       start_b, abort_b, busy_b, done_b, rd_en_b, rot_valid_b, wr_en_b;
   logic [0:0] rd_addr_b, rot_col_b, wr_addr_b;

   row_rotation_scheduler dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .busy(busy_a), .done(done_a),
      .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rot_valid(rot_valid_a), .rot_col(rot_col_a),
      .wr_en(wr_en_a), .wr_addr(wr_addr_a)
   );

   row_rotation_scheduler #(.NROW(2), .NCOL(2), .MEM_LAT(2), .PIPE_LAT(0)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
      .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rot_valid(rot_valid_b), .rot_col(rot_col_b),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b)
   );

   typedef struct packed {
      logic       rd_en;
      logic [1:0] rd_addr;
      logic       rot_valid;
      logic [1:0] rot_col;
      logic       wr_en;
      logic [1:0] wr_addr;
      logic       busy;
      logic       done;
   } obs_t;

   typedef struct packed {
      logic start;
      obs_t exp;
   } vec_t;

   obs_t obs_a, obs_b;
   assign obs_a = {rd_en_a, rd_addr_a, rot_valid_a, rot_col_a, wr_en_a, wr_addr_a, busy_a, done_a};
   assign obs_b = {rd_en_b, 1'b0, rd_addr_b, rot_valid_b, 1'b0, rot_col_b,
                   wr_en_b, 1'b0, wr_addr_b, busy_b, done_b};

   vec_t tbl_a [21];
   vec_t tbl_b [10];

   int total = 0;
   int bad   = 0;

   function automatic vec_t v(input int s, input int rd, input int ra, input int rv, input int rc,
                              input int we, input int wa, input int b, input int d);
      vec_t r;
      r.start         = 1'(s);
      r.exp.rd_en     = 1'(rd);
      r.exp.rd_addr   = 2'(ra);
      r.exp.rot_valid = 1'(rv);
      r.exp.rot_col   = 2'(rc);
      r.exp.wr_en     = 1'(we);
      r.exp.wr_addr   = 2'(wa);
      r.exp.busy      = 1'(b);
      r.exp.done      = 1'(d);
      return r;
   endfunction

   task automatic check_obs(input string name, input logic [11:0] act, input logic [11:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %03h want %03h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_a(input string tag);
      for (int i = 0; i < 21; i++) begin
         start_a = tbl_a[i].start;
         check_obs($sformatf("%s_c%0d", tag, i), obs_a, tbl_a[i].exp);
         step();
      end
      start_a = 1'b0;
   endtask

   task automatic run_b(input string tag);
      for (int i = 0; i < 10; i++) begin
         start_b = tbl_b[i].start;
         check_obs($sformatf("%s_c%0d", tag, i), obs_b, tbl_b[i].exp);
         step();
      end
      start_b = 1'b0;
   endtask

   // Row-buffer RAW scoreboard: every read of a row must follow the write-back of its previous read.
   int wr_cnt [4];
   int rd_cnt [4];
   always @(negedge clk) begin
      if (rst || !busy_a) begin
         for (int r = 0; r < 4; r++) begin
            wr_cnt[r] = 0;
            rd_cnt[r] = 0;
         end
      end else begin
         if (rd_en_a) begin
            check_int($sformatf("raw_row%0d", rd_addr_a), wr_cnt[rd_addr_a], rd_cnt[rd_addr_a]);
            rd_cnt[rd_addr_a]++;
         end
         if (wr_en_a) wr_cnt[wr_addr_a]++;
      end
   end

   initial begin
      int done_cnt;
      int done_at [2];
      int activity;

      start_a = 1'b0; abort_a = 1'b0;
      start_b = 1'b0; abort_b = 1'b0;

      //                s  rd ra rv rc we wa b  d
      tbl_a[0]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl_a[1]  = v(0, 1, 0, 0, 0, 0, 0, 1, 0);
      tbl_a[2]  = v(0, 1, 1, 1, 0, 0, 0, 1, 0);
      tbl_a[3]  = v(0, 1, 2, 1, 0, 1, 0, 1, 0);
      tbl_a[4]  = v(0, 1, 3, 1, 0, 1, 1, 1, 0);
      tbl_a[5]  = v(0, 0, 0, 1, 0, 1, 2, 1, 0);
      tbl_a[6]  = v(0, 0, 0, 0, 0, 1, 3, 1, 0);
      tbl_a[7]  = v(0, 1, 1, 0, 0, 0, 0, 1, 0);
      tbl_a[8]  = v(0, 1, 2, 1, 1, 0, 0, 1, 0);
      tbl_a[9]  = v(0, 1, 3, 1, 1, 1, 1, 1, 0);
      tbl_a[10] = v(0, 0, 0, 1, 1, 1, 2, 1, 0);
      tbl_a[11] = v(0, 0, 0, 0, 0, 1, 3, 1, 0);
      tbl_a[12] = v(0, 1, 2, 0, 0, 0, 0, 1, 0);
      tbl_a[13] = v(0, 1, 3, 1, 2, 0, 0, 1, 0);
      tbl_a[14] = v(0, 0, 0, 1, 2, 1, 2, 1, 0);
      tbl_a[15] = v(0, 0, 0, 0, 0, 1, 3, 1, 0);
      tbl_a[16] = v(0, 1, 3, 0, 0, 0, 0, 1, 0);
      tbl_a[17] = v(0, 0, 0, 1, 3, 0, 0, 1, 0);
      tbl_a[18] = v(0, 0, 0, 0, 0, 1, 3, 1, 0);
      tbl_a[19] = v(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tbl_a[20] = v(0, 0, 0, 0, 0, 0, 0, 0, 0);

      tbl_b[0]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl_b[1]  = v(0, 1, 0, 0, 0, 0, 0, 1, 0);
      tbl_b[2]  = v(0, 1, 1, 0, 0, 0, 0, 1, 0);
      tbl_b[3]  = v(0, 0, 0, 1, 0, 1, 0, 1, 0);
      tbl_b[4]  = v(0, 0, 0, 1, 0, 1, 1, 1, 0);
      tbl_b[5]  = v(0, 1, 1, 0, 0, 0, 0, 1, 0);
      tbl_b[6]  = v(0, 0, 0, 0, 0, 0, 0, 1, 0);
      tbl_b[7]  = v(0, 0, 0, 1, 1, 1, 1, 1, 0);
      tbl_b[8]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tbl_b[9]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_obs("reset_a", obs_a, 12'h000);
      check_obs("reset_b", obs_b, 12'h000);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Full jobs, both configurations
      run_a("job_a");
      run_b("job_b");

      // start held for 40 cycles: exactly two jobs, second issues at cycle 21
      done_cnt   = 0;
      done_at[0] = -1;
      done_at[1] = -1;
      for (int i = 0; i < 60; i++) begin
         start_a = (i < 40);
         if (i == 20) check_int("hold_rd_c20", int'(rd_en_a), 0);
         if (i == 21) check_int("hold_rd_c21", int'(rd_en_a), 1);
         if (done_a) begin
            if (done_cnt < 2) done_at[done_cnt] = i;
            done_cnt++;
         end
         step();
      end
      start_a = 1'b0;
      check_int("hold_done_cnt", done_cnt, 2);
      check_int("hold_done1", done_at[0], 19);
      check_int("hold_done2", done_at[1], 39);
      repeat (3) step();

      // abort mid column 1: nothing from the next cycle on, no done
      activity = 0;
      for (int i = 0; i < 31; i++) begin
         start_a = (i == 0);
         abort_a = (i == 9);
         if (i == 9)  check_obs("abort_c9", obs_a, tbl_a[9].exp);
         if (i == 10) check_int("abort_busy_c10", int'(busy_a), 0);
         if (i >= 10) activity += int'(rd_en_a) + int'(wr_en_a) + int'(done_a) + int'(busy_a)
                                + int'(rot_valid_a);
         step();
      end
      abort_a = 1'b0;
      check_int("abort_quiet", activity, 0);
      run_a("post_abort");

      // Async reset mid-cycle during a job
      for (int i = 0; i < 5; i++) begin
         start_a = (i == 0);
         step();
      end
      start_a = 1'b0;
      check_obs("prerst_c5", obs_a, tbl_a[5].exp);
      #2 rst = 1'b1;
      #1;
      check_obs("async_rst_a", obs_a, 12'h000);
      check_obs("async_rst_b", obs_b, 12'h000);
      step();
      @(negedge clk);
      rst = 1'b0;
      step();
      run_a("post_rst");
      run_b("post_rst_b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
